// File: rtl/ps2_move_decoder_pkg.sv
// Shared scan-code constants, receiver state encoding and key-to-command map
// for the PS/2 move decoder.
package ps2_move_decoder_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_DOWN,
        CMD_ROT
    } cmd_e;

    // Extended codes are the arrow keys; plain codes are the WASD cluster.
    function automatic cmd_e map_key(input logic ext, input logic [7:0] code);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (ext) begin
            case (code)
                SC_LEFT:  cmd = CMD_LEFT;
                SC_RIGHT: cmd = CMD_RIGHT;
                SC_DOWN:  cmd = CMD_DOWN;
                SC_UP:    cmd = CMD_ROT;
                default:  cmd = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_A:    cmd = CMD_LEFT;
                SC_D:    cmd = CMD_RIGHT;
                SC_S:    cmd = CMD_DOWN;
                SC_W:    cmd = CMD_ROT;
                default: cmd = CMD_NONE;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ps2_move_decoder_rx.sv
// PS/2 frame receiver: synchronises the raw lines, detects falling clock edges,
// reassembles 11-bit frames and flags framing, parity and timeout errors.
module ps2_move_decoder_rx
    import ps2_move_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          data_meta_q, data_sync_q;
    logic          fall_c;
    rx_state_e     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    // Synchronisers idle high so reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall_c = clk_prev_q & ~clk_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = '0;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (!fall_c && state_q != RX_IDLE) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (fall_c) begin
                    if (!data_sync_q) begin
                        state_d  = RX_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (fall_c) begin
                    shift_d  = {data_sync_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fall_c) begin
                    par_d   = data_sync_q;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall_c) begin
                    state_d = RX_IDLE;
                    if (data_sync_q && (^{shift_q, par_q})) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // A stalled partial frame is dropped after TIMEOUT_CYCLES quiet cycles.
        if (!fall_c && state_q != RX_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign err_o        = err_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// Turns received PS/2 scan codes into one-cycle Tetris move commands,
// tracking E0 (extended) and F0 (break) prefixes.
module ps2_move_decoder
    import ps2_move_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left,
    output logic       right,
    output logic       down,
    output logic       ro,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    cmd_e       cmd_c;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       left_q, left_d;
    logic       right_q, right_d;
    logic       down_q, down_d;
    logic       ro_q, ro_d;

    ps2_move_decoder_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .err_o       (rx_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            down_q  <= 1'b0;
            ro_q    <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            left_q  <= left_d;
            right_q <= right_d;
            down_q  <= down_d;
            ro_q    <= ro_d;
        end
    end

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        down_d  = 1'b0;
        ro_d    = 1'b0;
        cmd_c   = map_key(ext_q, rx_byte);

        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            case (rx_byte)
                SC_E0: ext_d = 1'b1;
                SC_F0: brk_d = 1'b1;
                default: begin
                    // Break codes only clear the prefix state; makes fire a command.
                    if (!brk_q) begin
                        left_d  = (cmd_c == CMD_LEFT);
                        right_d = (cmd_c == CMD_RIGHT);
                        down_d  = (cmd_c == CMD_DOWN);
                        ro_d    = (cmd_c == CMD_ROT);
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    assign left       = left_q;
    assign right      = right_q;
    assign down       = down_q;
    assign ro         = ro_q;
    assign scan_code  = rx_byte;
    assign scan_valid = rx_valid;
    assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: bit-bangs PS/2 frames and checks
// decoded pulses, debug byte, errors, timeout and reset behaviour.
module tb_ps2_move_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       left, right, down, ro;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int n_left = 0, n_right = 0, n_down = 0, n_ro = 0;
    int n_sv = 0, n_err = 0, n_multi = 0;
    int last_sv = 0, last_left = 0, last_err = 0, last_pin_fall = 0;
    logic [7:0] last_code = 8'h00;
    logic pin_prev = 1'b1;

    int s_left, s_right, s_down, s_ro, s_sv, s_err;

    ps2_move_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .left      (left),
        .right     (right),
        .down      (down),
        .ro        (ro),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (left)  begin n_left++;  last_left = cyc; end
        if (right) n_right++;
        if (down)  n_down++;
        if (ro)    n_ro++;
        if (scan_valid) begin n_sv++; last_sv = cyc; last_code = scan_code; end
        if (frame_err)  begin n_err++; last_err = cyc; end
        if ($countones({left, right, down, ro}) > 1) n_multi++;
        if (pin_prev && !ps2_clk) last_pin_fall = cyc;
        pin_prev = ps2_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_left = n_left; s_right = n_right; s_down = n_down; s_ro = n_ro;
        s_sv = n_sv; s_err = n_err;
    endtask

    function automatic int cmd_delta();
        return (n_left - s_left) + (n_right - s_right) + (n_down - s_down) + (n_ro - s_ro);
    endfunction

    // Frame bits sent LSB first: start, d0..d7, parity, stop.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            wait_cycles(10);
            ps2_clk = 1'b0;
            wait_cycles(20);
            ps2_clk = 1'b1;
            wait_cycles(10);
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic good_par);
        logic p;
        p = good_par ? ~(^b) : (^b);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic good_par);
        send_bits(mk_frame(b, good_par), 11);
        wait_cycles(5);
    endtask

    initial begin
        // Reset state
        wait_cycles(3);
        check("reset_cmds", {28'd0, left, right, down, ro}, 32'h0);
        check("reset_scan", {22'd0, scan_valid, frame_err, scan_code}, 32'h0);
        rst = 1'b0;
        wait_cycles(5);

        // Plain A make -> left one cycle after scan_valid
        snap();
        send_byte(8'h1C, 1'b1);
        check("a_sv", n_sv - s_sv, 1);
        check("a_code", last_code, 8'h1C);
        check("a_left", n_left - s_left, 1);
        check("a_only", cmd_delta(), 1);
        check("a_lat", last_left - last_sv, 1);
        check("a_err", n_err - s_err, 0);

        // E0,75 -> one rotate, after 75 only
        snap();
        send_byte(8'hE0, 1'b1);
        check("e0_nopulse", cmd_delta(), 0);
        send_byte(8'h75, 1'b1);
        check("up_ro", n_ro - s_ro, 1);
        check("up_only", cmd_delta(), 1);

        // E0,F0,75 release, then bare 75 must not be extended
        snap();
        send_byte(8'hE0, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h75, 1'b1);
        check("uprel_none", cmd_delta(), 0);
        send_byte(8'h75, 1'b1);
        check("bare75_none", cmd_delta(), 0);
        check("rel_sv", n_sv - s_sv, 4);

        // W release then W make
        snap();
        send_byte(8'hF0, 1'b1);
        send_byte(8'h1D, 1'b1);
        check("wrel_none", cmd_delta(), 0);
        send_byte(8'h1D, 1'b1);
        check("w_ro", n_ro - s_ro, 1);
        check("w_only", cmd_delta(), 1);

        // E0 then 6B with bad parity; error clears ext
        snap();
        send_byte(8'hE0, 1'b1);
        send_byte(8'h6B, 1'b0);
        check("par_err", n_err - s_err, 1);
        check("par_nosv", n_sv - s_sv, 1);
        send_byte(8'h6B, 1'b1);
        check("par_noleft", n_left - s_left, 0);
        check("par_sv2", n_sv - s_sv, 2);
        check("par_code", last_code, 8'h6B);

        // Stall after start + 4 data bits; timeout fires ~100 cycles later
        snap();
        send_bits(mk_frame(8'h23, 1'b1), 5);
        check("tmo_early", n_err - s_err, 0);
        wait_cycles(150);
        check("tmo_err", n_err - s_err, 1);
        check("tmo_lat", 32'((last_err - last_pin_fall) >= 100 && (last_err - last_pin_fall) <= 106), 1);
        check("tmo_nosv", n_sv - s_sv, 0);
        send_byte(8'h23, 1'b1);
        check("d_right", n_right - s_right, 1);
        check("d_only", cmd_delta(), 1);

        // Reset mid-frame, then a fresh S frame
        send_bits(mk_frame(8'hE0, 1'b1), 4);
        check("pre_rst_code", scan_code, 8'h23);
        rst = 1'b1;
        wait_cycles(1);
        check("rst_cmds", {28'd0, left, right, down, ro}, 32'h0);
        check("rst_scan", {22'd0, scan_valid, frame_err, scan_code}, 32'h0);
        rst = 1'b0;
        wait_cycles(5);
        snap();
        send_byte(8'h1B, 1'b1);
        check("s_down", n_down - s_down, 1);
        check("s_only", cmd_delta(), 1);
        check("s_code", last_code, 8'h1B);
        check("s_noerr", n_err - s_err, 0);

        check("onehot", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
